// File: rtl/pht_updater.sv
// pht_updater: FIFO-buffered read-modify-write of PHT saturating counters.
// Optional PHT_SKIP_SAT_EN: suppress table writes whose counter value would not change.
module pht_updater #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [ADDR_W-1:0] res_idx,
    input  logic              res_taken,
    output logic [ADDR_W-1:0] pht_addr,
    input  logic [DATA_W-1:0] pht_rd_data,
    output logic              pht_wr_en,
    output logic [DATA_W-1:0] pht_wr_data,
    output logic              busy,
    output logic [15:0]       upd_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t state, state_nx;
    logic [ADDR_W:0] fifo [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic push, pop, taken;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] old, nv;

    assign res_ready = !reset && cnt != (PW+1)'(FIFO_DEPTH);
    assign push = res_valid && res_ready;
    assign pop = state == IDLE && cnt != '0;
    assign busy = cnt != '0 || state != IDLE;
    assign pht_addr = idx;
    assign pht_wr_data = pht_wr_en ? nv : '0;
`ifdef PHT_SKIP_SAT_EN
    assign pht_wr_en = !reset && state == WR && nv != old;
`else
    assign pht_wr_en = !reset && state == WR;
`endif

    always_comb begin
        nv = taken ? (&old ? old : old + 1'b1) : (|old ? old - 1'b1 : old);
        state_nx = state == IDLE ? (pop ? RD : IDLE) : state == RD ? WR : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            idx     <= '0;
            taken   <= 1'b0;
            old     <= '0;
            upd_cnt <= '0;
        end else begin
            state <= state_nx;
            if (push) begin
                fifo[wp] <= {res_idx, res_taken};
                wp <= wp + 1'b1;
            end
            if (pop) begin
                {idx, taken} <= fifo[rp];
                rp <= rp + 1'b1;
            end
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
            if (state == RD) old <= pht_rd_data;
            if (pht_wr_en) upd_cnt <= upd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pht_updater.sv
// tb_pht_updater: directed and random checks of pht_updater against a queue-based
// saturating-counter reference model; the bench also owns the PHT array.
module tb_pht_updater;
    localparam int AW = 10, DW = 2, MAXV = (1 << DW) - 1;
`ifdef PHT_SKIP_SAT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, res_valid = 1'b0, res_taken = 1'b0;
    logic [AW-1:0] res_idx = '0;
    logic res_ready, pht_wr_en, busy;
    logic [AW-1:0] pht_addr;
    logic [DW-1:0] pht_rd_data, pht_wr_data;
    logic [15:0] upd_cnt;
    logic [DW-1:0] mem [1 << AW];
    logic ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_val = '0;
    int tests = 0, fails = 0, wr_cnt = 0;
    int ref_tbl [1 << AW];
    typedef struct {int idx; bit taken;} res_t;
    res_t q[$];

    pht_updater dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_taken(res_taken), .pht_addr(pht_addr),
        .pht_rd_data(pht_rd_data), .pht_wr_en(pht_wr_en), .pht_wr_data(pht_wr_data),
        .busy(busy), .upd_cnt(upd_cnt)
    );

    always #5 clk = ~clk;
    assign pht_rd_data = mem[pht_addr];
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_val;
        if (pht_wr_en) mem[pht_addr] <= pht_wr_data;
    end

    function automatic int sat(int v, bit tk);
        return tk ? (v == MAXV ? v : v + 1) : (v == 0 ? 0 : v - 1);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drop_skips();
        while (SKIP && q.size() > 0 && sat(ref_tbl[q[0].idx], q[0].taken) == ref_tbl[q[0].idx])
            void'(q.pop_front());
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (pht_wr_en === 1'b1) begin
                res_t e;
                int nv;
                drop_skips();
                chk("write_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    nv = sat(ref_tbl[e.idx], e.taken);
                    chk("wr_addr", 32'(pht_addr), e.idx);
                    chk("wr_data", 32'(pht_wr_data), nv);
                    ref_tbl[e.idx] = nv;
                    wr_cnt++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        res_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", 32'(res_ready), 0);
        reset = 1'b0;
        q.delete();
        wr_cnt = 0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_upd_cnt", 32'(upd_cnt), 0);
        chk("rst_wr_en", 32'(pht_wr_en), 0);
        chk("rst_ready_high", 32'(res_ready), 1);
    endtask

    task automatic load(int a, int v);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = AW'(a);
        ld_val = DW'(v);
        ref_tbl[a] = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic offer(int a, bit tk, output bit acc);
        @(negedge clk);
        res_valid = 1'b1;
        res_idx = AW'(a);
        res_taken = tk;
        acc = res_ready;
        if (acc) q.push_back('{a, tk});
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        res_valid = 1'b0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < 300), 1);
        drop_skips();
        chk("queue_empty", 32'(q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc, saw_full;
        int i, cyc;
        fork monitor(); join_none
        do_reset();
        chk("rst_addr", 32'(pht_addr), 0);

        // single update with exact latency
        load(5, 1);
        offer(5, 1'b1, acc);
        @(negedge clk); res_valid = 1'b0;
        chk("lat_t1_wr_en", 32'(pht_wr_en), 0);
        @(negedge clk);
        chk("lat_t2_wr_en", 32'(pht_wr_en), 0);
        @(negedge clk);
        chk("lat_t3_wr_en", 32'(pht_wr_en), 1);
        chk("lat_t3_addr", 32'(pht_addr), 5);
        chk("lat_t3_data", 32'(pht_wr_data), 2);
        @(negedge clk);
        chk("single_busy", 32'(busy), 0);
        chk("single_upd_cnt", 32'(upd_cnt), 1);
        chk("single_table", 32'(mem[5]), 2);

        // saturation at both ends
        do_reset();
        load(7, 3);
        offer(7, 1'b1, acc);
        drain();
        chk("sat_hi_upd_cnt", 32'(upd_cnt), SKIP ? 0 : 1);
        chk("sat_hi_table", 32'(mem[7]), 3);
        load(9, 0);
        offer(9, 1'b0, acc);
        drain();
        chk("sat_lo_upd_cnt", 32'(upd_cnt), SKIP ? 0 : 2);
        chk("sat_lo_table", 32'(mem[9]), 0);

        // same-index chain
        do_reset();
        load(3, 0);
        for (int k = 0; k < 4; k++) offer(3, 1'b1, acc);
        drain();
        chk("chain_table", 32'(mem[3]), 3);
        chk("chain_upd_cnt", 32'(upd_cnt), SKIP ? 3 : 4);

        // backpressure with a continuous stream
        do_reset();
        for (int a = 0; a < 8; a++) load(a, 1);
        i = 0; cyc = 0; saw_full = 1'b0;
        while (i < 8 && cyc < 100) begin
            offer(i, bit'(i & 1), acc);
            if (acc) i++;
            else saw_full = 1'b1;
            cyc++;
        end
        chk("bp_ready_dropped", 32'(saw_full), 1);
        chk("bp_all_pushed", i, 8);
        drain();
        chk("bp_writes", wr_cnt, 8);
        chk("bp_upd_cnt", 32'(upd_cnt), 8);

        // reset during the first WR
        do_reset();
        for (int a = 20; a < 23; a++) load(a, 1);
        for (int a = 20; a < 23; a++) offer(a, 1'b1, acc);
        @(posedge clk);
        #1 reset = 1'b1; res_valid = 1'b0; q.delete();
        @(negedge clk);
        chk("mid_rst_wr_en", 32'(pht_wr_en), 0);
        chk("mid_rst_ready", 32'(res_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0; wr_cnt = 0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_upd_cnt", 32'(upd_cnt), 0);
        repeat (12) @(negedge clk);
        chk("mid_rst_no_writes", wr_cnt, 0);
        chk("mid_rst_table", 32'(mem[20]), 1);

        // random traffic against the model
        do_reset();
        for (int a = 0; a < 16; a++) load(a, int'($urandom_range(0, MAXV)));
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) != 0) offer(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), acc);
            else begin
                @(negedge clk);
                res_valid = 1'b0;
            end
        end
        drain();
        chk("rand_upd_cnt", 32'(upd_cnt), wr_cnt);
        for (int a = 0; a < 16; a++) chk($sformatf("rand_table_%0d", a), 32'(mem[a]), ref_tbl[a]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
